// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
package display_pkg;

  localparam int N_DIGITS_DEF = 4;
  localparam int MAX_DIGITS   = 8;

  localparam logic [MAX_DIGITS-1:0] ALL_OFF = '1;

  // Index width for a digit counter; never narrower than one bit.
  function automatic int clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_DIGITS-1:0] onehot_n(input logic [2:0] idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-PRESCALE slot counter; flags the last cycle of a slot and the
// leading dead-time window in which every digit must be off.
module scan_prescaler #(
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic wrap,
  output logic in_dead
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign wrap = enable && (count == LAST);

  generate
    if (DEAD == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (count < CW'(DEAD));
    end
  endgenerate

endmodule

// File: rtl/display_scan_mux.sv
// Scan driver for a common-anode multi-digit 7-segment display: tear-free
// value updates at frame boundaries, blanking, leading-zero suppression.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 500
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_enable,
  input  logic [4*N_DIGITS-1:0]        i_value,
  input  logic                         i_load,
  input  logic [N_DIGITS-1:0]          i_blank_mask,
  input  logic                         i_lz_en,
  output logic [3:0]                   o_bits,
  output logic [N_DIGITS-1:0]          o_digit_en_n,
  output logic [clog2(N_DIGITS)-1:0]   o_digit_idx,
  output logic                         o_frame_tick
);

  localparam int IW = clog2(N_DIGITS);
  localparam int VW = 4 * N_DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

  logic                wrap;
  logic                in_dead;
  logic                boundary;
  logic [IW-1:0]       idx;
  logic [VW-1:0]       disp;
  logic [VW-1:0]       shadow;
  logic                pending;
  logic                wrapped;
  logic [N_DIGITS-1:0] lz_dark;
  logic [3:0]          cur_nib;
  logic                dark;

  scan_prescaler #(
    .PRESCALE (PRESCALE),
    .DEAD     (DEAD)
  ) u_prescaler (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .enable  (i_enable),
    .wrap    (wrap),
    .in_dead (in_dead)
  );

  assign boundary = wrap && (idx == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx     <= '0;
      disp    <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      wrapped <= boundary;
      if (wrap) begin
        idx <= boundary ? '0 : idx + IW'(1);
      end
      if (i_load) begin
        shadow <= i_value;
      end
      // A load landing on the boundary cycle bypasses the shadow so it is not lost.
      if (!i_enable && i_load) begin
        disp    <= i_value;
        pending <= 1'b0;
      end else if (boundary && (i_load || pending)) begin
        disp    <= i_load ? i_value : shadow;
        pending <= 1'b0;
      end else if (i_load) begin
        pending <= 1'b1;
      end
    end
  end

  // Digit k is a leading zero when it and every digit above it are zero.
  always_comb begin : lz_calc
    logic zero_above;
    lz_dark    = '0;
    zero_above = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above && (disp[4*k +: 4] == 4'h0);
      lz_dark[k] = i_lz_en && zero_above;
    end
  end

  assign cur_nib = disp[{idx, 2'b00} +: 4];
  assign dark    = !i_enable || in_dead || i_blank_mask[idx] || lz_dark[idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bits       <= 4'h0;
      o_digit_en_n <= N_DIGITS'(ALL_OFF);
      o_digit_idx  <= '0;
      o_frame_tick <= 1'b0;
    end else begin
      o_bits       <= cur_nib;
      o_digit_en_n <= dark ? N_DIGITS'(ALL_OFF) : N_DIGITS'(onehot_n(3'(idx)));
      o_digit_idx  <= idx;
      o_frame_tick <= wrapped && i_enable;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux (PRESCALE=4, DEAD=1, 4 digits), plus
// a DEAD=0 instance sharing the same stimulus.
module tb_display_scan_mux;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int D  = 1;
  localparam int FL = N * P;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic        load   = 1'b0;
  logic        lz_en  = 1'b0;
  logic [15:0] value  = 16'h0;
  logic [3:0]  mask   = 4'h0;

  logic [3:0] bits,  bits0;
  logic [3:0] en_n,  en_n0;
  logic [1:0] idx,   idx0;
  logic       tick,  tick0;

  display_scan_mux #(.N_DIGITS(N), .PRESCALE(P), .DEAD(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_value(value),
    .i_load(load), .i_blank_mask(mask), .i_lz_en(lz_en),
    .o_bits(bits), .o_digit_en_n(en_n), .o_digit_idx(idx), .o_frame_tick(tick)
  );

  display_scan_mux #(.N_DIGITS(N), .PRESCALE(P), .DEAD(0)) dut_nodead (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_value(value),
    .i_load(load), .i_blank_mask(mask), .i_lz_en(lz_en),
    .o_bits(bits0), .o_digit_en_n(en_n0), .o_digit_idx(idx0), .o_frame_tick(tick0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0] bits;
    logic [3:0] en_n;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  exp_t sb[$];

  // Model state: position within the frame, values and pending flag.
  int          m_t = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_shadow = 16'h0;
  logic        m_pending = 1'b0;
  logic        m_tick_next = 1'b0;

  task automatic model_reset();
    m_t = 0; m_disp = 16'h0; m_shadow = 16'h0;
    m_pending = 1'b0; m_tick_next = 1'b0;
    sb.delete();
  endtask

  // One clock: predict the outputs the DUT registers at this edge, then
  // compare at the following falling edge.
  task automatic step();
    exp_t e;
    int   k;
    int   ph;
    logic zeros;
    logic dk;
    @(posedge clk);
    k  = m_t / P;
    ph = m_t % P;
    zeros = 1'b1;
    for (int j = k; j < N; j++) if (m_disp[4*j +: 4] != 4'h0) zeros = 1'b0;
    dk = !enable || (ph < D) || mask[k] || (lz_en && k > 0 && zeros);
    e.bits = m_disp[4*k +: 4];
    e.en_n = dk ? 4'hF : ~(4'b0001 << k);
    e.idx  = 2'(k);
    e.tick = enable && m_tick_next;
    sb.push_back(e);
    m_tick_next = 1'b0;
    if (load) begin
      m_shadow = value;
      m_pending = 1'b1;
    end
    if (!enable) begin
      if (load) begin
        m_disp = value;
        m_pending = 1'b0;
      end
    end else begin
      if (m_t == FL - 1) begin
        m_tick_next = 1'b1;
        if (m_pending) begin
          m_disp = m_shadow;
          m_pending = 1'b0;
        end
      end
      m_t = (m_t + 1) % FL;
    end
    @(negedge clk);
    e = sb.pop_front();
    check("bits", 32'(bits), 32'(e.bits));
    check("digit_en_n", 32'(en_n), 32'(e.en_n));
    check("digit_idx", 32'(idx), 32'(e.idx));
    check("frame_tick", 32'(tick), 32'(e.tick));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Advance until the upcoming cycle is frame position target.
  task automatic wait_t(input int target);
    for (int i = 0; i < 2 * FL && m_t != target; i++) step();
    check("wait_t", 32'(m_t), 32'(target));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dark0;
    int ticks0;

    #12;
    check("rst_bits", 32'(bits), 32'h0);
    check("rst_en_n", 32'(en_n), 32'hF);
    check("rst_idx", 32'(idx), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_en_n_nodead", 32'(en_n0), 32'hF);
    model_reset();
    rst_n  = 1'b1;
    enable = 1'b1;

    // Basic scan with a pending load released at the first boundary.
    step();
    do_load(16'h1234);
    run(3 * FL);

    // Leading-zero suppression.
    lz_en = 1'b1;
    do_load(16'h0050);
    run(2 * FL + 2);
    do_load(16'h0000);
    run(2 * FL + 2);
    lz_en = 1'b0;

    // Blanking of digit 2.
    mask = 4'b0100;
    do_load(16'hFFFF);
    run(2 * FL + 2);
    mask = 4'b0000;

    // Without dead time every enabled cycle lights exactly one digit.
    step();
    dark0  = 0;
    ticks0 = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      step();
      if (en_n0 == 4'hF) dark0++;
      if (tick0) ticks0++;
    end
    check("nodead_dark_cycles", 32'(dark0), 32'd0);
    check("nodead_frame_ticks", 32'(ticks0), 32'd2);

    // Load on the boundary cycle overrides an earlier mid-frame load.
    wait_t(6);
    do_load(16'hAAAA);
    wait_t(FL - 1);
    do_load(16'hBBBB);
    run(FL + 4);
    wait_t(6);
    do_load(16'hAAAA);
    run(2 * FL);

    // Freeze during slot 2, then resume.
    wait_t(9);
    enable = 1'b0;
    run(8);
    enable = 1'b1;
    run(FL + 3);

    // Load while disabled reaches the display directly.
    wait_t(5);
    enable = 1'b0;
    do_load(16'h5A5A);
    run(4);
    enable = 1'b1;
    run(FL);

    // Asynchronous reset in the middle of a lit slot.
    wait_t(10);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bits", 32'(bits), 32'h0);
    check("arst_en_n", 32'(en_n), 32'hF);
    check("arst_idx", 32'(idx), 32'h0);
    check("arst_tick", 32'(tick), 32'h0);
    check("arst_en_n_nodead", 32'(en_n0), 32'hF);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(2 * FL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
